// File: rtl/product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// product_accumulator_pkg
// Shared definitions for the product accumulator stage: the default product
// width (must track the 4x4 array multiplier output) and the group FSM states.
// No ports.
// -----------------------------------------------------------------------------
package product_accumulator_pkg;

    // Width of the product delivered by the upstream 4x4 multiplier.
    localparam int PROD_W_DEF = 8;

    // Group FSM: IDLE waits for the first beat, ACCUM sums further beats,
    // DONE presents the closed group until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_acc_sat_add.sv
// -----------------------------------------------------------------------------
// acc_sat_add
// Combinational ACC_W-bit unsigned adder with carry-out. The carry-out marks
// that the true sum no longer fits in ACC_W bits.
// Optional feature macro: ACC_SATURATE_EN
//   defined     -> on carry-out the sum clamps to all-ones. Because every addend
//                  is non-negative, a clamped accumulator stays clamped for the
//                  rest of the group without any extra state.
//   not defined -> the sum wraps modulo 2**ACC_W.
// Ports:
//   acc_i    in  ACC_W  running accumulator value
//   prod_i   in  ACC_W  zero-extended product
//   sum_o    out ACC_W  wrapped or clamped sum
//   carry_o  out 1      carry-out of the full-width add
// -----------------------------------------------------------------------------
module acc_sat_add #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] prod_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full_s;

    // One-bit-wider add so the carry-out is visible.
    always_comb begin
        full_s  = {1'b0, acc_i} + {1'b0, prod_i};
        carry_o = full_s[ACC_W];
`ifdef ACC_SATURATE_EN
        if (full_s[ACC_W]) begin
            sum_o = {ACC_W{1'b1}};
        end else begin
            sum_o = full_s[ACC_W-1:0];
        end
`else
        sum_o = full_s[ACC_W-1:0];
`endif
    end

endmodule : acc_sat_add

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Sums the multiplier's product stream into groups. A group closes on in_last
// or when its beat count reaches 2**CNT_W-1; the closed group is then held on
// out_* with out_valid until out_ready. One bubble cycle per group (DONE).
// Optional feature macro: ACC_SATURATE_EN (clamp instead of wrap, see
// acc_sat_add). Handshake and timing are identical in both builds.
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       in_product/in_last valid
//   in_ready    out  1       stage can accept a beat (low only in DONE)
//   in_product  in   PROD_W  unsigned product
//   in_last     in   1       beat closes the current group
//   out_valid   out  1       group result held on out_*
//   out_ready   in   1       consumer takes the result
//   out_sum     out  ACC_W   group sum (0 when out_valid is low)
//   out_count   out  CNT_W   beats in group (0 when out_valid is low)
//   out_ovf     out  1       sum exceeded 2**ACC_W-1 in this group
// -----------------------------------------------------------------------------
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;

    logic               beat_s;
    logic               close_s;
    logic [ACC_W-1:0]   add_base_s;
    logic [ACC_W-1:0]   add_prod_s;
    logic [ACC_W-1:0]   add_sum_s;
    logic               add_carry_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               ovf_next_s;

    assign in_ready   = (state_q != DONE);
    assign beat_s     = in_valid & in_ready;
    assign add_prod_s = {{(ACC_W-PROD_W){1'b0}}, in_product};

    // Group start (IDLE) sums from zero so the previous group's state never leaks in.
    always_comb begin
        if (state_q == IDLE) begin
            add_base_s = {ACC_W{1'b0}};
            cnt_next_s = CNT_ONE;
            ovf_next_s = add_carry_s;
        end else begin
            add_base_s = acc_q;
            cnt_next_s = cnt_q + CNT_ONE;
            ovf_next_s = ovf_q | add_carry_s;
        end
        close_s = in_last | (cnt_next_s == CNT_MAX);
    end

    acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i   (add_base_s),
        .prod_i  (add_prod_s),
        .sum_o   (add_sum_s),
        .carry_o (add_carry_s)
    );

    // Next-state and output-register logic for the group FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat_s) begin
                    acc_d = add_sum_s;
                    cnt_d = cnt_next_s;
                    ovf_d = ovf_next_s;
                    if (close_s) begin
                        // Result registers load with the closing beat so out_*
                        // are valid the very next cycle.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_sum_d   = add_sum_s;
                        out_cnt_d   = cnt_next_s;
                        out_ovf_d   = ovf_next_s;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_sum_d   = {ACC_W{1'b0}};
                    out_cnt_d   = {CNT_W{1'b0}};
                    out_ovf_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
                out_sum_d   = {ACC_W{1'b0}};
                out_cnt_d   = {CNT_W{1'b0}};
                out_ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {ACC_W{1'b0}};
            out_cnt_q   <= {CNT_W{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
// Three instances share one input stream: A (ACC_W=16, CNT_W=8),
// B (ACC_W=10) and C (CNT_W=2). Each test selects one instance, resets all,
// and checks that instance against a group-level reference model that keeps
// the unbounded integer sum of the open group and derives the wrapped or
// clamped result from it. Honours ACC_SATURATE_EN like the design.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_product;
    logic       in_last;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_sum;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [9:0]  b_out_sum;
    logic [7:0]  b_out_count;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [15:0] c_out_sum;
    logic [1:0]  c_out_count;

    int   sel;
    logic obs_ready, obs_valid, obs_ovf;
    int   obs_sum, obs_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int     m_accw, m_cap;
    bit     m_hold, m_acc;
    longint m_sum;
    int     m_cnt;
    int     e_sum, e_cnt;
    bit     e_ovf;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
        .out_ovf(a_out_ovf));

    product_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
        .out_ovf(b_out_ovf));

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_sum(c_out_sum), .out_count(c_out_count),
        .out_ovf(c_out_ovf));

    always_comb begin
        case (sel)
            0: begin
                obs_ready = a_in_ready; obs_valid = a_out_valid; obs_ovf = a_out_ovf;
                obs_sum = int'(a_out_sum); obs_cnt = int'(a_out_count);
            end
            1: begin
                obs_ready = b_in_ready; obs_valid = b_out_valid; obs_ovf = b_out_ovf;
                obs_sum = int'(b_out_sum); obs_cnt = int'(b_out_count);
            end
            default: begin
                obs_ready = c_in_ready; obs_valid = c_out_valid; obs_ovf = c_out_ovf;
                obs_sum = int'(c_out_sum); obs_cnt = int'(c_out_count);
            end
        endcase
    end

    function automatic int group_result(input longint s, input int accw);
        longint mx;
        mx = (64'd1 << accw) - 64'd1;
`ifdef ACC_SATURATE_EN
        return (s > mx) ? int'(mx) : int'(s);
`else
        return int'(s & mx);
`endif
    endfunction

    task automatic model_clear();
        m_hold = 1'b0; m_acc = 1'b0; m_sum = 0; m_cnt = 0;
        e_sum = 0; e_cnt = 0; e_ovf = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_product = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic select(input int s);
        sel = s;
        case (s)
            0:       begin m_accw = 16; m_cap = 255; end
            1:       begin m_accw = 10; m_cap = 255; end
            default: begin m_accw = 16; m_cap = 3;   end
        endcase
        do_reset();
    endtask

    // Apply one cycle of inputs, advance the model over the edge, return at edge+1.
    task automatic drive(input bit v, input logic [7:0] p, input bit l, input bit r);
        in_valid = v; in_product = p; in_last = l; out_ready = r;
        m_acc = 1'b0;
        if (m_hold) begin
            if (r) m_hold = 1'b0;
        end else if (v) begin
            m_acc = 1'b1;
            m_sum = m_sum + longint'(p);
            m_cnt = m_cnt + 1;
            if (l || m_cnt == m_cap) begin
                m_hold = 1'b1;
                e_sum  = group_result(m_sum, m_accw);
                e_ovf  = (m_sum > ((64'd1 << m_accw) - 64'd1));
                e_cnt  = m_cnt;
                m_sum  = 0;
                m_cnt  = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        select(0);
        n_total++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", obs_ready); end
        n_total++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", obs_valid); end
        n_total++; if (obs_sum !== 0 || obs_cnt !== 0 || obs_ovf !== 1'b0) begin
            n_bad++; $display("FAIL reset_outs sum=%0h cnt=%0d ovf=%b want 0/0/0", obs_sum, obs_cnt, obs_ovf); end
    endtask

    task automatic test_basic_group();
        select(0);
        drive(1'b1, 8'h0F, 1'b0, 1'b1);
        drive(1'b1, 8'hE1, 1'b0, 1'b1);
        n_total++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%b want=0", obs_valid); end
        drive(1'b1, 8'h01, 1'b1, 1'b1);
        n_total++; if (obs_valid !== 1'b1 || obs_sum !== 32'h00F1 || obs_cnt !== 3 || obs_ovf !== 1'b0) begin
            n_bad++; $display("FAIL basic_result valid=%b sum=%0h cnt=%0d ovf=%b want 1/f1/3/0", obs_valid, obs_sum, obs_cnt, obs_ovf); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_sum !== 0) begin
            n_bad++; $display("FAIL basic_idle valid=%b ready=%b sum=%0h want 0/1/0", obs_valid, obs_ready, obs_sum); end
    endtask

    task automatic test_single_beat();
        select(0);
        drive(1'b1, 8'hE1, 1'b1, 1'b1);
        n_total++; if (obs_ready !== 1'b0 || obs_sum !== 32'h00E1 || obs_cnt !== 1) begin
            n_bad++; $display("FAIL single_result ready=%b sum=%0h cnt=%0d want 0/e1/1", obs_ready, obs_sum, obs_cnt); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_back got=%b want=1", obs_ready); end
    endtask

    task automatic test_back_pressure();
        select(0);
        drive(1'b1, 8'h09, 1'b0, 1'b0);
        drive(1'b1, 8'h04, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (obs_valid !== 1'b1 || obs_sum !== 32'h000D || obs_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold_%0d valid=%b sum=%0h ready=%b want 1/d/0", i, obs_valid, obs_sum, obs_ready); end
            // in_valid asserted while held must be ignored
            drive(1'b1, 8'h55, 1'b1, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_sum !== 0) begin
            n_bad++; $display("FAIL hold_release ready=%b valid=%b sum=%0h want 1/0/0", obs_ready, obs_valid, obs_sum); end
    endtask

    task automatic test_overflow();
        int want;
`ifdef ACC_SATURATE_EN
        want = 32'h3FF;
`else
        want = 32'h065;
`endif
        select(1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hE1, (i == 4), 1'b1);
        n_total++; if (obs_valid !== 1'b1 || obs_sum !== want || obs_ovf !== 1'b1 || obs_cnt !== 5) begin
            n_bad++; $display("FAIL ovf_result valid=%b sum=%0h ovf=%b cnt=%0d want 1/%0h/1/5", obs_valid, obs_sum, obs_ovf, obs_cnt, want); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'h10, 1'b1, 1'b1);
        n_total++; if (obs_sum !== 32'h010 || obs_ovf !== 1'b0) begin
            n_bad++; $display("FAIL ovf_cleared sum=%0h ovf=%b want 10/0", obs_sum, obs_ovf); end
    endtask

    task automatic test_count_cap();
        int accepted = 0;
        int iter = 0;
        select(2);
        while (accepted < 4 && iter < 20) begin
            drive(1'b1, 8'h01, 1'b0, 1'b1);
            iter++;
            if (m_acc) accepted++;
            n_total++; if (obs_ready !== !m_hold) begin
                n_bad++; $display("FAIL cap_ready_it%0d got=%b want=%b", iter, obs_ready, !m_hold); end
            if (m_acc && accepted == 3) begin
                n_total++; if (obs_valid !== 1'b1 || obs_cnt !== 3 || obs_sum !== 32'h0003) begin
                    n_bad++; $display("FAIL cap_result valid=%b cnt=%0d sum=%0h want 1/3/3", obs_valid, obs_cnt, obs_sum); end
            end
        end
        n_total++; if (iter != 5) begin n_bad++; $display("FAIL cap_timing iterations=%0d want=5", iter); end
        n_total++; if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            n_bad++; $display("FAIL cap_new_group valid=%b ready=%b want 0/1", obs_valid, obs_ready); end
    endtask

    task automatic test_async_reset();
        select(0);
        drive(1'b1, 8'h30, 1'b0, 1'b0);
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_sum !== 0 || obs_cnt !== 0) begin
            n_bad++; $display("FAIL arst_group ready=%b valid=%b sum=%0h cnt=%0d", obs_ready, obs_valid, obs_sum, obs_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        drive(1'b1, 8'h05, 1'b1, 1'b0);
        n_total++; if (obs_valid !== 1'b1 || obs_sum !== 32'h0005 || obs_cnt !== 1) begin
            n_bad++; $display("FAIL arst_after valid=%b sum=%0h cnt=%0d want 1/5/1", obs_valid, obs_sum, obs_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (obs_valid !== 1'b0 || obs_sum !== 0 || obs_ready !== 1'b1) begin
            n_bad++; $display("FAIL arst_done valid=%b sum=%0h ready=%b want 0/0/1", obs_valid, obs_sum, obs_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            select(s);
            for (int c = 0; c < 300; c++) begin
                bit v, l, r;
                logic [7:0] p;
                v = ($urandom_range(0, 3) != 0);
                p = 8'($urandom_range(0, 255));
                l = ($urandom_range(0, 7) == 0);
                r = ($urandom_range(0, 2) != 0);
                drive(v, p, l, r);
                n_total++;
                if (obs_ready !== !m_hold || obs_valid !== m_hold ||
                    obs_sum !== (m_hold ? e_sum : 0) || obs_cnt !== (m_hold ? e_cnt : 0) ||
                    obs_ovf !== (m_hold ? e_ovf : 1'b0)) begin
                    n_bad++;
                    $display("FAIL rand_s%0d_c%0d got rdy=%b vld=%b sum=%0h cnt=%0d ovf=%b want rdy=%b vld=%b sum=%0h cnt=%0d ovf=%b",
                             s, c, obs_ready, obs_valid, obs_sum, obs_cnt, obs_ovf,
                             !m_hold, m_hold, m_hold ? e_sum : 0, m_hold ? e_cnt : 0, m_hold ? e_ovf : 1'b0);
                end
            end
        end
    endtask

    initial begin
        sel = 0;
        rst_n = 1'b0;
        test_reset();
        test_basic_group();
        test_single_beat();
        test_back_pressure();
        test_overflow();
        test_count_cap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_product_accumulator
